axi4_lite_cfg_sequencer: RTL and testbench

AXI4_LITE_CFG_SEQUENCER -- requirements
Module: axi4_lite_cfg_sequencer

---
 rtl/axi4_lite_cfg_sequencer_pkg.sv | 27 ++
 rtl/axi4_lite_cfg_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_axi4_lite_cfg_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_cfg_sequencer_pkg.sv
`default_nettype none
// =============================================================================
// axi4_lite_cfg_sequencer_pkg : FSM state type, error codes and AXI response codes
// Revision : 1.0
// =============================================================================
package axi4_lite_cfg_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WRESP = 3'd2,
    S_RD    = 3'd3,
    S_RDATA = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6,
    S_FAIL  = 3'd7
  } cfg_seq_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_RESP     = 2'd1;
  localparam logic [1:0] ERR_MISMATCH = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [1:0] OKAY = 2'b00;

endpackage
`default_nettype wire

// File: rtl/axi4_lite_cfg_sequencer.sv
`default_nettype none
// =============================================================================
// axi4_lite_cfg_sequencer : writes a register table over AXI4-Lite, optional readback
// Revision : 1.0
// =============================================================================
module axi4_lite_cfg_sequencer
  import axi4_lite_cfg_sequencer_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int TIMEOUT     = 255,
  parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic             ACLK,
  input  logic             reset,
  input  logic             start,
  input  logic             verify_en,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [7:0]       tbl_addr,
  input  logic [31:0]      tbl_data,
  output logic [7:0]       AWADDR,
  output logic [2:0]       AWPROT,
  output logic             AWVALID,
  input  logic             AWREADY,
  output logic [31:0]      WDATA,
  output logic [3:0]       WSTRB,
  output logic             WVALID,
  input  logic             WREADY,
  input  logic [1:0]       BRESP,
  input  logic             BVALID,
  output logic             BREADY,
  output logic [7:0]       ARADDR,
  output logic [2:0]       ARPROT,
  output logic             ARVALID,
  input  logic             ARREADY,
  input  logic [31:0]      RDATA,
  input  logic [1:0]       RRESP,
  input  logic             RVALID,
  output logic             RREADY,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [IDX_W-1:0] err_idx
);

  cfg_seq_state_t   r_state;
  cfg_seq_state_t   w_state_nxt;
  logic [1:0]       w_fail_code;
  logic [IDX_W-1:0] r_idx;
  logic             r_verify;
  logic [15:0]      r_tmo;
  logic [7:0]       r_awaddr;
  logic [7:0]       r_araddr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;
  logic             r_awvalid;
  logic             r_wvalid;
  logic             r_arvalid;
  logic             r_err;
  logic [1:0]       r_err_code;
  logic [IDX_W-1:0] r_err_idx;

  logic w_last;
  logic w_tmo_hit;
  logic w_aw_ok;
  logic w_w_ok;
  logic w_entry;

  assign w_last    = (r_idx == IDX_W'(NUM_ENTRIES - 1));
  assign w_tmo_hit = (r_tmo == 16'(TIMEOUT - 1));
  // A channel counts as complete once its VALID has dropped or is being accepted now.
  assign w_aw_ok   = !r_awvalid || AWREADY;
  assign w_w_ok    = !r_wvalid || WREADY;
  assign w_entry   = (w_state_nxt != r_state);

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fail_code = ERR_NONE;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_WR;
      S_WR: begin
        if (w_aw_ok && w_w_ok) w_state_nxt = S_WRESP;
        else if (w_tmo_hit) begin w_state_nxt = S_FAIL; w_fail_code = ERR_TIMEOUT; end
      end
      S_WRESP: begin
        if (BVALID) begin
          if (BRESP != OKAY) begin w_state_nxt = S_FAIL; w_fail_code = ERR_RESP; end
          else               w_state_nxt = r_verify ? S_RD : S_NEXT;
        end else if (w_tmo_hit) begin w_state_nxt = S_FAIL; w_fail_code = ERR_TIMEOUT; end
      end
      S_RD: begin
        if (ARREADY) w_state_nxt = S_RDATA;
        else if (w_tmo_hit) begin w_state_nxt = S_FAIL; w_fail_code = ERR_TIMEOUT; end
      end
      S_RDATA: begin
        if (RVALID) begin
          if (RRESP != OKAY)         begin w_state_nxt = S_FAIL; w_fail_code = ERR_RESP;     end
          else if (RDATA != r_wdata) begin w_state_nxt = S_FAIL; w_fail_code = ERR_MISMATCH; end
          else                       w_state_nxt = S_NEXT;
        end else if (w_tmo_hit) begin w_state_nxt = S_FAIL; w_fail_code = ERR_TIMEOUT; end
      end
      S_NEXT:  w_state_nxt = w_last ? S_DONE : S_WR;
      S_DONE:  w_state_nxt = S_IDLE;
      S_FAIL:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The fetch index leads r_idx so tbl_addr/tbl_data are valid on the edge entering WR.
  always_comb begin
    busy    = (r_state != S_IDLE);
    done    = (r_state == S_DONE);
    BREADY  = (r_state == S_WRESP);
    RREADY  = (r_state == S_RDATA);
    tbl_idx = r_idx;
    if (r_state == S_IDLE)               tbl_idx = '0;
    else if (r_state == S_NEXT && !w_last) tbl_idx = r_idx + IDX_W'(1);
  end

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      r_idx      <= '0;
      r_verify   <= 1'b0;
      r_tmo      <= '0;
      r_awaddr   <= '0;
      r_araddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_err_idx  <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_idx      <= '0;
        r_verify   <= verify_en;
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
        r_err_idx  <= '0;
      end
      if (r_state == S_NEXT && !w_last) r_idx <= r_idx + IDX_W'(1);
      if (w_entry && w_state_nxt == S_FAIL) begin
        r_err      <= 1'b1;
        r_err_code <= w_fail_code;
        r_err_idx  <= r_idx;
      end

      if (w_entry && w_state_nxt == S_WR) begin
        r_awaddr  <= tbl_addr;
        r_wdata   <= tbl_data;
        r_wstrb   <= 4'hF;
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
      end else begin
        if (AWREADY || w_state_nxt != S_WR) r_awvalid <= 1'b0;
        if (WREADY  || w_state_nxt != S_WR) r_wvalid  <= 1'b0;
      end

      if (w_entry && w_state_nxt == S_RD) begin
        r_araddr  <= r_awaddr;
        r_arvalid <= 1'b1;
      end else if (ARREADY || w_state_nxt != S_RD) begin
        r_arvalid <= 1'b0;
      end

      if (w_entry) r_tmo <= '0;
      else if (r_state inside {S_WR, S_WRESP, S_RD, S_RDATA}) r_tmo <= r_tmo + 16'd1;
    end
  end

  assign AWADDR   = r_awaddr;
  assign AWPROT   = 3'b000;
  assign AWVALID  = r_awvalid;
  assign WDATA    = r_wdata;
  assign WSTRB    = r_wstrb;
  assign WVALID   = r_wvalid;
  assign ARADDR   = r_araddr;
  assign ARPROT   = 3'b000;
  assign ARVALID  = r_arvalid;
  assign err      = r_err;
  assign err_code = r_err_code;
  assign err_idx  = r_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_cfg_sequencer.sv
`default_nettype none
// =============================================================================
// tb_axi4_lite_cfg_sequencer : table-driven scenarios against a behavioural AXI4-Lite slave
// Revision : 1.0
// =============================================================================
module tb_axi4_lite_cfg_sequencer;
  import axi4_lite_cfg_sequencer_pkg::*;

  localparam int NE  = 4;
  localparam int TMO = 8;
  localparam int IW  = 2;

  logic          ACLK;
  logic          reset;
  logic          start;
  logic          verify_en;
  logic [IW-1:0] tbl_idx;
  logic [7:0]    tbl_addr;
  logic [31:0]   tbl_data;
  logic [7:0]    AWADDR;
  logic [2:0]    AWPROT;
  logic          AWVALID;
  logic          AWREADY;
  logic [31:0]   WDATA;
  logic [3:0]    WSTRB;
  logic          WVALID;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY;
  logic [7:0]    ARADDR;
  logic [2:0]    ARPROT;
  logic          ARVALID;
  logic          ARREADY;
  logic [31:0]   RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [IW-1:0] err_idx;

  axi4_lite_cfg_sequencer #(.NUM_ENTRIES(NE), .TIMEOUT(TMO)) dut (
    .ACLK(ACLK), .reset(reset), .start(start), .verify_en(verify_en),
    .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .err_idx(err_idx)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [7:0]  addr_mem [NE];
  logic [31:0] data_mem [NE];
  assign tbl_addr = addr_mem[tbl_idx];
  assign tbl_data = data_mem[tbl_idx];

  logic [71:0] w_outs;
  assign w_outs = {tbl_idx, AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
                   ARADDR, ARPROT, ARVALID, RREADY, busy, done, err, err_code, err_idx};

  typedef struct {
    int verify; int aw_lag; int w_lag; int b_err; int b_never; int rd_bad;
    int exp_wr; int exp_rd; int exp_done; int exp_err; int exp_code; int exp_eidx;
    int exp_split; int exp_bready;
  } vec_t;
  vec_t vecs [8];

  typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q [$];
  int  sb_ptr;

  int n_cmp  = 0;
  int n_fail = 0;

  // slave knobs and observations
  int k_aw_lag, k_w_lag, k_b_err, k_b_never, k_rd_bad;
  int aw_wait, w_wait, wr_cnt, rd_cnt, stab_err, bready_cnt;
  bit aw_got, w_got, b_pend, r_pend, split;
  logic [7:0]  cur_addr;
  logic [31:0] cur_data;
  logic [3:0]  cur_strb;
  logic p_awvalid, p_awready, p_wvalid, p_wready, p_bvalid, p_bready;
  logic p_arvalid, p_arready, p_rvalid, p_rready;
  logic [7:0]  p_awaddr, p_araddr;
  logic [31:0] p_wdata;
  logic [3:0]  p_wstrb;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic slave_step();
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    if (reset) begin
      aw_wait = 0; w_wait = 0; wr_cnt = 0; rd_cnt = 0; stab_err = 0; bready_cnt = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; split = 0; sb_ptr = 0;
      cur_addr = '0; cur_data = '0; cur_strb = '0;
      AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0;
      RVALID = 0; RDATA = 0; RRESP = 0;
      p_awvalid = 0; p_awready = 0; p_wvalid = 0; p_wready = 0; p_bvalid = 0; p_bready = 0;
      p_arvalid = 0; p_arready = 0; p_rvalid = 0; p_rready = 0;
      p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wstrb = '0;
      return;
    end
    aw_hs = p_awvalid && p_awready;
    w_hs  = p_wvalid && p_wready;
    b_hs  = p_bvalid && p_bready;
    ar_hs = p_arvalid && p_arready;
    r_hs  = p_rvalid && p_rready;
    if (b_hs) b_pend = 0;
    if (r_hs) r_pend = 0;
    if (aw_hs) begin aw_got = 1; cur_addr = p_awaddr; end
    if (w_hs)  begin w_got = 1; cur_data = p_wdata; cur_strb = p_wstrb; end
    if (aw_got && w_got) begin
      aw_got = 0; w_got = 0; b_pend = 1; wr_cnt++;
      if (sb_ptr < exp_q.size()) begin
        chk("sb_awaddr", cur_addr, exp_q[sb_ptr].addr);
        chk("sb_wdata", cur_data, exp_q[sb_ptr].data);
        chk("sb_wstrb", cur_strb, 4'hF);
        sb_ptr++;
      end else begin
        chk("sb_unexpected_write_count", wr_cnt, exp_q.size());
      end
    end
    if (ar_hs) begin
      rd_cnt++; r_pend = 1;
      chk("araddr_matches_write", p_araddr, cur_addr);
    end
    if (p_awvalid && !aw_hs && (!AWVALID || AWADDR !== p_awaddr)) stab_err++;
    if (p_wvalid && !w_hs && (!WVALID || WDATA !== p_wdata)) stab_err++;
    if (p_arvalid && !ar_hs && (!ARVALID || ARADDR !== p_araddr)) stab_err++;
    if (AWVALID && !WVALID) split = 1;
    if (BREADY) bready_cnt++;

    if (AWVALID) begin
      if (aw_wait >= k_aw_lag) AWREADY = 1; else begin AWREADY = 0; aw_wait++; end
    end else begin AWREADY = 0; aw_wait = 0; end
    if (WVALID) begin
      if (w_wait >= k_w_lag) WREADY = 1; else begin WREADY = 0; w_wait++; end
    end else begin WREADY = 0; w_wait = 0; end
    BVALID  = b_pend && (k_b_never == 0);
    BRESP   = (wr_cnt - 1 == k_b_err) ? 2'b10 : 2'b00;
    ARREADY = ARVALID;
    RVALID  = r_pend;
    RRESP   = 2'b00;
    RDATA   = cur_data ^ ((wr_cnt - 1 == k_rd_bad) ? 32'h1 : 32'h0);

    p_awvalid = AWVALID; p_awready = AWREADY; p_awaddr = AWADDR;
    p_wvalid = WVALID; p_wready = WREADY; p_wdata = WDATA; p_wstrb = WSTRB;
    p_bvalid = BVALID; p_bready = BREADY;
    p_arvalid = ARVALID; p_arready = ARREADY; p_araddr = ARADDR;
    p_rvalid = RVALID; p_rready = RREADY;
  endtask

  task automatic wait_idle(output int dcnt);
    bit fin;
    fin = 0; dcnt = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge ACLK);
      if (done) dcnt++;
      if (!busy) fin = 1;
    end
    if (!fin) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_idle: busy=%0b after 400 cycles, expected 0", busy);
    end
  endtask

  task automatic hold_reset(input int nwr, input int aw_lag);
    @(negedge ACLK);
    reset = 1; start = 0; verify_en = 0;
    repeat (2) @(negedge ACLK);
    chk("reset_outputs_zero", w_outs, '0);
    k_aw_lag = aw_lag; k_w_lag = 0; k_b_err = -1; k_b_never = 0; k_rd_bad = -1;
    exp_q.delete();
    for (int j = 0; j < nwr; j++) exp_q.push_back('{addr: addr_mem[j], data: data_mem[j]});
    reset = 0;
  endtask

  task automatic pulse_start(input bit ver);
    @(negedge ACLK); start = 1; verify_en = ver;
    @(negedge ACLK); start = 0; verify_en = 0;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int dcnt;
    hold_reset(v.exp_wr, v.aw_lag);
    k_w_lag = v.w_lag; k_b_err = v.b_err; k_b_never = v.b_never; k_rd_bad = v.rd_bad;
    pulse_start(v.verify != 0);
    wait_idle(dcnt);
    chk($sformatf("v%0d_done_pulses", id), dcnt, v.exp_done);
    chk($sformatf("v%0d_err", id), err, v.exp_err);
    chk($sformatf("v%0d_err_code", id), err_code, v.exp_code);
    chk($sformatf("v%0d_err_idx", id), err_idx, v.exp_eidx);
    chk($sformatf("v%0d_writes", id), wr_cnt, v.exp_wr);
    chk($sformatf("v%0d_reads", id), rd_cnt, v.exp_rd);
    chk($sformatf("v%0d_w_before_aw", id), split, v.exp_split);
    chk($sformatf("v%0d_bready_cycles", id), bready_cnt, v.exp_bready);
    chk($sformatf("v%0d_payload_unstable", id), stab_err, 0);
  endtask

  initial begin
    int dcnt;
    bit found;
    addr_mem = '{8'h10, 8'h24, 8'h38, 8'h4C};
    data_mem = '{32'h1111_0001, 32'hCAFE_0002, 32'hDEAD_BEEE, 32'h0BAD_F00D};
    //         ver awl wl berr bnev rbad  wr rd dn er code eidx split bready
    vecs[0] = '{0,  0,  0, -1,  0,  -1,   4, 0, 1, 0, 0,   0,   0,    4};
    vecs[1] = '{1,  0,  0, -1,  0,  -1,   4, 4, 1, 0, 0,   0,   0,    4};
    vecs[2] = '{0,  3,  0, -1,  0,  -1,   4, 0, 1, 0, 0,   0,   1,    4};
    vecs[3] = '{1,  0,  0, -1,  0,   2,   3, 3, 0, 1, 2,   2,   0,    3};
    vecs[4] = '{0,  0,  0,  1,  0,  -1,   2, 0, 0, 1, 1,   1,   0,    2};
    vecs[5] = '{0,  0,  0, -1,  1,  -1,   1, 0, 0, 1, 3,   0,   0,    8};
    vecs[6] = '{1,  0,  2, -1,  0,  -1,   4, 4, 1, 0, 0,   0,   0,    4};
    vecs[7] = '{1,  0,  0,  3,  0,  -1,   4, 3, 0, 1, 1,   3,   0,    4};

    reset = 1; start = 0; verify_en = 0;
    k_aw_lag = 0; k_w_lag = 0; k_b_err = -1; k_b_never = 0; k_rd_bad = -1;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0;
    RVALID = 0; RDATA = 0; RRESP = 0;

    fork
      forever begin @(negedge ACLK); slave_step(); end
    join_none

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // asynchronous reset while a read address is outstanding, then a clean restart
    hold_reset(4, 0);
    pulse_start(1'b1);
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge ACLK);
      if (ARVALID) found = 1;
    end
    chk("arvalid_reached", found, 1'b1);
    #2 reset = 1;
    #1 chk("async_reset_outputs_zero", w_outs, '0);
    repeat (2) @(negedge ACLK);
    exp_q.delete();
    for (int j = 0; j < NE; j++) exp_q.push_back('{addr: addr_mem[j], data: data_mem[j]});
    reset = 0;
    pulse_start(1'b0);
    chk("restart_tbl_idx", tbl_idx, 2'd0);
    chk("restart_awaddr", AWADDR, addr_mem[0]);
    chk("restart_awvalid", AWVALID, 1'b1);
    wait_idle(dcnt);
    chk("restart_done_pulses", dcnt, 1);
    chk("restart_writes", wr_cnt, NE);

    // start while busy must be ignored, including its verify_en
    hold_reset(4, 3);
    pulse_start(1'b0);
    repeat (3) @(negedge ACLK);
    start = 1; verify_en = 1;
    @(negedge ACLK); start = 0; verify_en = 0;
    wait_idle(dcnt);
    chk("busy_start_done_pulses", dcnt, 1);
    chk("busy_start_writes", wr_cnt, NE);
    chk("busy_start_reads", rd_cnt, 0);
    chk("busy_start_err", err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
